// File: rtl/tournament_bp_pkg.sv
// Shared encodings and helpers for the tournament branch predictor.
package tournament_bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CNT_RESET = WNT;

    localparam int unsigned HIST_WIDTH_DEFAULT = 8;

    function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic inc);
        if (inc) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/tournament_bp_counter_table.sv
// Array of 2-bit saturating counters: async read port, sync inc/dec update port, sync reset.
module bp_counter_table
    import tournament_bp_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_WIDTH-1:0] rd_idx_i,
    output logic [1:0]           rd_cnt_o,
    input  logic                 upd_en_i,
    input  logic [IDX_WIDTH-1:0] upd_idx_i,
    input  logic                 upd_inc_i
);

    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    logic [1:0] cnt_q [DEPTH];
    logic [1:0] upd_cnt_d;

    // No write-to-read bypass: a same-cycle lookup sees the old value.
    assign rd_cnt_o = cnt_q[rd_idx_i];

    always_comb begin
        upd_cnt_d = cnt_step(cnt_q[upd_idx_i], upd_inc_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_RESET;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= upd_cnt_d;
        end
    end

endmodule

// File: rtl/tournament_bp.sv
// Tournament (gshare + local, chooser-selected) branch predictor with speculative GHR.
// Optional statistics counters are built when BP_STATS_EN is defined.
module tournament_bp
    import tournament_bp_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned HIST_WIDTH  = HIST_WIDTH_DEFAULT,
    parameter int unsigned LOCAL_IDX   = 8,
    parameter int unsigned CHOOSER_IDX = 8
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   F_PC_i,
    input  logic                  F_is_branch_i,
    input  logic                  F_stall_i,
    output logic                  F_predict_o,
    output logic                  F_global_predict_o,
    output logic                  F_local_predict_o,
    output logic [HIST_WIDTH-1:0] F_global_history_o,
    input  logic [PC_WIDTH-1:0]   MD_PC_i,
    input  logic                  MD_train_vaild_i,
    input  logic                  MD_train_taken_i,
    input  logic                  MD_train_predict_i,
    input  logic                  MD_train_global_predict_i,
    input  logic                  MD_train_local_predict_i,
    input  logic [HIST_WIDTH-1:0] MD_train_global_history_i,
    output logic [31:0]           stat_train_cnt_o,
    output logic [31:0]           stat_miss_cnt_o
);

    logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
    logic [1:0]            gsh_cnt, loc_cnt, cho_cnt;
    logic                  mispredict;
    logic                  cho_upd_en;
    logic                  unused_pc;

    assign unused_pc = ^{F_PC_i, MD_PC_i};

    bp_counter_table #(.IDX_WIDTH(HIST_WIDTH)) u_gshare (
        .clk_i     (clk_i),
        .rst_i     (rst),
        .rd_idx_i  (F_PC_i[HIST_WIDTH+1:2] ^ ghr_q),
        .rd_cnt_o  (gsh_cnt),
        .upd_en_i  (MD_train_vaild_i),
        .upd_idx_i (MD_PC_i[HIST_WIDTH+1:2] ^ MD_train_global_history_i),
        .upd_inc_i (MD_train_taken_i)
    );

    bp_counter_table #(.IDX_WIDTH(LOCAL_IDX)) u_local (
        .clk_i     (clk_i),
        .rst_i     (rst),
        .rd_idx_i  (F_PC_i[LOCAL_IDX+1:2]),
        .rd_cnt_o  (loc_cnt),
        .upd_en_i  (MD_train_vaild_i),
        .upd_idx_i (MD_PC_i[LOCAL_IDX+1:2]),
        .upd_inc_i (MD_train_taken_i)
    );

    // Chooser moves only when the components disagreed, toward whichever was right.
    assign cho_upd_en = MD_train_vaild_i &
                        (MD_train_global_predict_i != MD_train_local_predict_i);

    bp_counter_table #(.IDX_WIDTH(CHOOSER_IDX)) u_chooser (
        .clk_i     (clk_i),
        .rst_i     (rst),
        .rd_idx_i  (F_PC_i[CHOOSER_IDX+1:2]),
        .rd_cnt_o  (cho_cnt),
        .upd_en_i  (cho_upd_en),
        .upd_idx_i (MD_PC_i[CHOOSER_IDX+1:2]),
        .upd_inc_i (MD_train_global_predict_i == MD_train_taken_i)
    );

    assign F_global_predict_o = gsh_cnt[1];
    assign F_local_predict_o  = loc_cnt[1];
    assign F_predict_o        = cho_cnt[1] ? gsh_cnt[1] : loc_cnt[1];
    assign F_global_history_o = ghr_q;

    assign mispredict = MD_train_vaild_i & (MD_train_predict_i != MD_train_taken_i);

    // Recovery wins over a same-cycle fetch shift; that fetch is wrong-path.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {MD_train_global_history_i[HIST_WIDTH-2:0], MD_train_taken_i};
        end else if (F_is_branch_i & ~F_stall_i) begin
            ghr_d = {ghr_q[HIST_WIDTH-2:0], F_predict_o};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_train_q, stat_train_d;
    logic [31:0] stat_miss_q, stat_miss_d;

    always_comb begin
        stat_train_d = stat_train_q + {31'd0, MD_train_vaild_i};
        stat_miss_d  = stat_miss_q + {31'd0, mispredict};
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            stat_train_q <= '0;
            stat_miss_q  <= '0;
        end else begin
            stat_train_q <= stat_train_d;
            stat_miss_q  <= stat_miss_d;
        end
    end

    assign stat_train_cnt_o = stat_train_q;
    assign stat_miss_cnt_o  = stat_miss_q;
`else
    assign stat_train_cnt_o = '0;
    assign stat_miss_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_tournament_bp.sv
// Bench for tournament_bp: directed steps then random traffic against an array-based model.
module tb_tournament_bp;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        br, stall;
    logic        predict, gpred, lpred;
    logic [7:0]  ghr;
    logic [31:0] mpc;
    logic        mv, mt, mp, mg, ml;
    logic [7:0]  mh;
    logic [31:0] stat_train, stat_miss;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_gsh [256];
    int m_loc [256];
    int m_cho [256];
    int m_ghr;
    int m_train;
    int m_miss;

    tournament_bp dut (
        .clk_i                     (clk),
        .rst                       (rst),
        .F_PC_i                    (pc),
        .F_is_branch_i             (br),
        .F_stall_i                 (stall),
        .F_predict_o               (predict),
        .F_global_predict_o        (gpred),
        .F_local_predict_o         (lpred),
        .F_global_history_o        (ghr),
        .MD_PC_i                   (mpc),
        .MD_train_vaild_i          (mv),
        .MD_train_taken_i          (mt),
        .MD_train_predict_i        (mp),
        .MD_train_global_predict_i (mg),
        .MD_train_local_predict_i  (ml),
        .MD_train_global_history_i (mh),
        .stat_train_cnt_o          (stat_train),
        .stat_miss_cnt_o           (stat_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bump(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int tbl_idx(input logic [31:0] a);
        return int'((a >> 2) % 256);
    endfunction

    function automatic bit m_fetch_pred();
        bit g, l;
        g = m_gsh[tbl_idx(pc) ^ m_ghr] >= 2;
        l = m_loc[tbl_idx(pc)] >= 2;
        return (m_cho[tbl_idx(pc)] >= 2) ? g : l;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 256; i++) begin
            m_gsh[i] = 1;
            m_loc[i] = 1;
            m_cho[i] = 1;
        end
        m_ghr   = 0;
        m_train = 0;
        m_miss  = 0;
    endtask

    task automatic m_clock();
        bit fp;
        int gi, li;
        fp = m_fetch_pred();
        if (rst) begin
            m_reset();
            return;
        end
        if (mv) begin
            gi = tbl_idx(mpc) ^ int'(mh);
            li = tbl_idx(mpc);
            m_gsh[gi] = bump(m_gsh[gi], mt);
            m_loc[li] = bump(m_loc[li], mt);
            if (mg != ml) m_cho[li] = bump(m_cho[li], mg == mt);
            m_train++;
            if (mp != mt) m_miss++;
        end
        if (mv && (mp != mt)) m_ghr = ((int'(mh) * 2) + int'(mt)) % 256;
        else if (br && !stall) m_ghr = ((m_ghr * 2) + int'(fp)) % 256;
    endtask

    task automatic check_all();
        int ep_tr, ep_mi;
        chk("global_predict", {31'd0, gpred}, {31'd0, m_gsh[tbl_idx(pc) ^ m_ghr] >= 2});
        chk("local_predict", {31'd0, lpred}, {31'd0, m_loc[tbl_idx(pc)] >= 2});
        chk("predict", {31'd0, predict}, {31'd0, m_fetch_pred()});
        chk("history", {24'd0, ghr}, m_ghr);
`ifdef BP_STATS_EN
        ep_tr = m_train;
        ep_mi = m_miss;
`else
        ep_tr = 0;
        ep_mi = 0;
`endif
        chk("stat_train", stat_train, ep_tr);
        chk("stat_miss", stat_miss, ep_mi);
    endtask

    // Drive one cycle of inputs, check lookup outputs, clock, advance the model.
    task automatic step(input logic r, input logic [31:0] p, input logic b, input logic s,
                        input logic v, input logic [31:0] tpc, input logic t, input logic pr,
                        input logic g, input logic l, input logic [7:0] h);
        rst = r; pc = p; br = b; stall = s;
        mv = v; mpc = tpc; mt = t; mp = pr; mg = g; ml = l; mh = h;
        #2;
        check_all();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    initial begin
        logic [31:0] rp, rt;
        logic [31:0] exp_tr, exp_mi;
        m_reset();
        rst = 1'b1; pc = '0; br = 1'b0; stall = 1'b0;
        mv = 1'b0; mpc = '0; mt = 1'b0; mp = 1'b0; mg = 1'b0; ml = 1'b0; mh = '0;
        @(posedge clk);
        #1;

        // Reset, with a training in the reset cycle that must be discarded
        step(1, 32'h100, 0, 0, 1, 32'h100, 1, 0, 1, 0, 8'h00);
        step(1, 32'h100, 0, 0, 0, 32'h0, 0, 0, 0, 0, 8'h00);
        chk("rst_predict", {31'd0, predict}, 0);
        chk("rst_gpred", {31'd0, gpred}, 0);
        chk("rst_lpred", {31'd0, lpred}, 0);
        chk("rst_history", {24'd0, ghr}, 32'h00);

        // Local entry 0x40 saturates at 11, then one not-taken brings it to 10
        for (int i = 0; i < 4; i++) begin
            step(0, 32'h100, 0, 0, 1, 32'h100, 1, 1, 0, 0, 8'h00);
            chk("local_taken_train", {31'd0, lpred}, 1);
        end
        step(0, 32'h100, 0, 0, 1, 32'h100, 0, 1, 0, 0, 8'h00);
        chk("local_after_nt", {31'd0, lpred}, 1);
        chk("history_after_nt", {24'd0, ghr}, 32'h00);

        // GHR shifts in taken predictions, then holds under stall
        step(0, 32'h100, 1, 0, 0, 32'h0, 0, 0, 0, 0, 8'h00);
        chk("ghr_shift1", {24'd0, ghr}, 32'h01);
        step(0, 32'h100, 1, 0, 0, 32'h0, 0, 0, 0, 0, 8'h00);
        chk("ghr_shift2", {24'd0, ghr}, 32'h03);
        step(0, 32'h100, 1, 0, 0, 32'h0, 0, 0, 0, 0, 8'h00);
        chk("ghr_shift3", {24'd0, ghr}, 32'h07);
        step(0, 32'h100, 1, 1, 0, 32'h0, 0, 0, 0, 0, 8'h00);
        chk("ghr_stall", {24'd0, ghr}, 32'h07);

        // Mispredict repair beats same-cycle fetch shift
        step(0, 32'h100, 1, 0, 1, 32'h200, 1, 0, 0, 0, 8'h05);
        chk("ghr_repair", {24'd0, ghr}, 32'h0B);

        // Chooser moves toward global; agreeing components leave it alone
        step(0, 32'h300, 0, 0, 1, 32'h300, 1, 1, 1, 0, 8'h0B);
        step(0, 32'h300, 0, 0, 1, 32'h300, 0, 0, 1, 1, 8'h55);
        chk("chooser_gpred", {31'd0, gpred}, 1);
        chk("chooser_lpred", {31'd0, lpred}, 0);
        chk("chooser_select_global", {31'd0, predict}, 1);

        // Statistics: 5 trains, 2 mispredicts
        step(1, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 8'h00);
        step(0, 32'h0, 0, 0, 1, 32'h104, 1, 1, 0, 0, 8'h00);
        step(0, 32'h0, 0, 0, 1, 32'h108, 1, 0, 0, 0, 8'h00);
        step(0, 32'h0, 0, 0, 0, 32'h10C, 1, 0, 0, 0, 8'h00);
        step(0, 32'h0, 0, 0, 1, 32'h10C, 0, 0, 1, 0, 8'h01);
        step(0, 32'h0, 0, 0, 1, 32'h110, 0, 1, 0, 1, 8'h02);
        step(0, 32'h0, 0, 0, 1, 32'h114, 1, 1, 1, 1, 8'h03);
`ifdef BP_STATS_EN
        exp_tr = 32'd5;
        exp_mi = 32'd2;
`else
        exp_tr = 32'd0;
        exp_mi = 32'd0;
`endif
        chk("stat_train_5", stat_train, exp_tr);
        chk("stat_miss_2", stat_miss, exp_mi);

        // Random traffic over a small PC set so entries collide and saturate
        for (int i = 0; i < 3000; i++) begin
            rp = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            rt = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            step($urandom_range(0, 99) < 2, rp, 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 1'($urandom), rt, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tournament_bp.md
Name: tournament_bp

Overview:
- Fetch-side tournament branch predictor. Produces the prediction and the training snapshot fields (predict, global/local component predictions, global history) that travel down the pipeline.
- Consumes the MD_train_* bundle returned at the memory/writeback end to update its tables.
- Holds the speculative global history register (GHR) and repairs it on a mispredict.

Parameters:
- PC_WIDTH, 32, PC width.
- HIST_WIDTH, 8, GHR width; gshare table has 2^HIST_WIDTH entries.
- LOCAL_IDX, 8, local (bimodal) table index bits.
- CHOOSER_IDX, 8, chooser table index bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- F_PC_i  in  PC_WIDTH  fetch PC.
- F_is_branch_i  in  1  fetch slot holds a conditional branch.
- F_stall_i  in  1  fetch stalled; GHR must not advance.
- F_predict_o  out  1  final taken prediction.
- F_global_predict_o  out  1  gshare component prediction.
- F_local_predict_o  out  1  local component prediction.
- F_global_history_o  out  HIST_WIDTH  GHR value used for this lookup.
- MD_PC_i  in  PC_WIDTH  PC of the training branch.
- MD_train_vaild_i  in  1  training bundle valid.
- MD_train_taken_i  in  1  actual outcome.
- MD_train_predict_i  in  1  final prediction made at fetch.
- MD_train_global_predict_i  in  1  gshare prediction made at fetch.
- MD_train_local_predict_i  in  1  local prediction made at fetch.
- MD_train_global_history_i  in  HIST_WIDTH  GHR snapshot taken at fetch.
- stat_train_cnt_o  out  32  training count (see Optional Feature).
- stat_miss_cnt_o  out  32  mispredict count (see Optional Feature).

Behaviour:
- Counters: all table entries are 2-bit saturating counters. Prediction = counter[1].
- Indexing:
  - gshare index = F_PC_i[HIST_WIDTH+1:2] ^ GHR.
  - local index = F_PC_i[LOCAL_IDX+1:2].
  - chooser index = F_PC_i[CHOOSER_IDX+1:2].
- Lookup is combinational, 0-cycle latency (asynchronous read).
  - F_predict_o = chooser[1] ? global : local.
  - F_global_history_o = current GHR.
- Reset: GHR = 0; every entry of all three tables = 2'b01 (weakly not-taken / weakly local). All outputs follow from these values: predictions 0, history 0, stat counters 0.
- Training, applied at the clock edge when MD_train_vaild_i = 1:
  - gshare entry at MD_PC_i[HIST_WIDTH+1:2] ^ MD_train_global_history_i and local entry at MD_PC_i[LOCAL_IDX+1:2]: increment if taken, else decrement, saturating at 0 and 3.
  - Chooser at MD_PC_i index updates only when global_predict != local_predict: increment if global_predict == taken, else decrement, saturating.
- GHR next-state, in priority order:
  1. rst → 0.
  2. Mispredict (MD_train_vaild_i & (MD_train_predict_i != MD_train_taken_i)) → {MD_train_global_history_i[HIST_WIDTH-2:0], MD_train_taken_i}.
  3. F_is_branch_i & ~F_stall_i → {GHR[HIST_WIDTH-2:0], F_predict_o}.
  4. Otherwise hold.
- A correctly predicted training never alters the GHR.
- Simultaneous lookup and train to the same entry: lookup returns the pre-update value; there is no bypass.
- Mispredict recovery overrides a same-cycle fetch shift; the wrong-path fetch is squashed upstream.
- MD_train_vaild_i = 0: the other MD_* inputs are ignored.
- Reset asserted mid-operation: tables and GHR are reinitialised on that edge. Training that arrives in the same cycle is discarded.

Optional Feature:
- Macro BP_STATS_EN.
- Defined:
  - stat_train_cnt_o increments on each valid training.
  - stat_miss_cnt_o increments on each valid mispredict.
  - Both are 32-bit wrapping counters, cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package/define file holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - table reset value WNT;
  - the history_WIDTH default.
- One sub-module, bp_counter_table: a parameterised array of 2-bit counters with one async read port, one synchronous saturating inc/dec update port and synchronous reset. It is instantiated three times (gshare, local, chooser).

Test Plan:
- Reset, then F_PC_i=0x100 → F_predict_o=0, F_global_predict_o=0, F_local_predict_o=0, F_global_history_o=0x00.
- Four trains on MD_PC_i=0x100, taken=1, history=0x00 → local entry 0x40 goes 01→10→11→11, and stays 11. One not-taken train → 10. Lookup of 0x100 → F_local_predict_o=1.
- With a taken-predicting entry, three cycles F_is_branch_i=1 → GHR 0x01, 0x03, 0x07. Asserting F_stall_i on the next cycle → GHR holds 0x07.
- Mispredict train (history=0x05, predict=0, taken=1) in the same cycle as F_is_branch_i=1 → next GHR = 0x0B, fetch shift ignored.
- Train with global_predict=1, local_predict=0, taken=1 → chooser 01→10. Next lookup of that PC → F_predict_o = F_global_predict_o. A train with global_predict == local_predict leaves the chooser unchanged.
- BP_STATS_EN defined: 5 valid trains, 2 of them mispredicts → stat_train_cnt_o=5, stat_miss_cnt_o=2. Undefined → both read 0.
